// File: rtl/cp0_nirq.sv
// cp0_nirq: minimal CP0 (SR/Cause/EPC/PRID) with interrupt and exception entry/return.
// Optional macro CP0_IRQ_LATCH_EN: edge-latched, write-1-to-clear interrupt pending bits.
`default_nettype none

module cp0_nirq #(
  parameter int          N_IRQ        = 6,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL     = 32'h2004_0007
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [4:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [31:0]      pc,
  input  logic             bd,
  input  logic [4:0]       exc_code,
  input  logic [N_IRQ-1:0] hw_int,
  input  logic             eret,
  output logic             req,
  output logic [31:0]      epc,
  output logic [31:0]      vector
);

  logic [N_IRQ-1:0] im;
  logic             exl;
  logic             ie;
  logic             cause_bd;
  logic [N_IRQ-1:0] cause_ip;
  logic [4:0]       cause_exc;
  logic [31:0]      epc_r;

  logic [N_IRQ-1:0] ip_src;
  logic             int_req;
  logic             exc_req;
  logic             wr_ok;
  logic [31:0]      epc_next;
  logic [31:0]      sr_val;
  logic [31:0]      cause_val;

  assign wr_ok = we & ~req;

`ifdef CP0_IRQ_LATCH_EN
  logic [N_IRQ-1:0] hw_prev;
  logic [N_IRQ-1:0] ip_latch;
  logic [N_IRQ-1:0] ip_clr;

  assign ip_src = ip_latch;
  assign ip_clr = (wr_ok && addr == 5'd13) ? wdata[10 +: N_IRQ] : '0;

  // A new rising edge wins over a software clear on the same line.
  always_ff @(posedge clk) begin
    if (reset) begin
      hw_prev  <= '0;
      ip_latch <= '0;
    end else begin
      hw_prev  <= hw_int;
      ip_latch <= (ip_latch & ~ip_clr) | (hw_int & ~hw_prev);
    end
  end
`else
  assign ip_src = hw_int;
`endif

  assign int_req  = ie & ~exl & (|(ip_src & im));
  assign exc_req  = ~exl & (exc_code != 5'd0);
  assign req      = int_req | exc_req;
  assign epc_next = (bd ? (pc - 32'd4) : pc) & 32'hFFFF_FFFC;
  assign epc      = epc_r;
  assign vector   = HANDLER_ADDR;

  always_ff @(posedge clk) begin
    if (reset) begin
      im        <= '0;
      exl       <= 1'b0;
      ie        <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= 5'd0;
      epc_r     <= 32'd0;
    end else begin
      cause_ip <= ip_src;
      if (req) begin
        exl       <= 1'b1;
        cause_bd  <= bd;
        cause_exc <= int_req ? 5'd0 : exc_code;
        epc_r     <= epc_next;
      end else begin
        if (we && addr == 5'd12) begin
          im  <= wdata[10 +: N_IRQ];
          exl <= wdata[1];
          ie  <= wdata[0];
        end
        if (we && addr == 5'd14) begin
          epc_r <= wdata;
        end
        // Return overrides any concurrent software write to EXL.
        if (eret) begin
          exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    sr_val                 = 32'd0;
    sr_val[10 +: N_IRQ]    = im;
    sr_val[1]              = exl;
    sr_val[0]              = ie;
    cause_val              = 32'd0;
    cause_val[31]          = cause_bd;
    cause_val[10 +: N_IRQ] = cause_ip;
    cause_val[6:2]         = cause_exc;
    case (addr)
      5'd12:   rdata = sr_val;
      5'd13:   rdata = cause_val;
      5'd14:   rdata = epc_r;
      5'd15:   rdata = PRID_VAL;
      default: rdata = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cp0_nirq.sv
// tb_cp0_nirq: directed scoreboard bench for cp0_nirq (default level-sensitive build,
// latch-build variant of the pending-bit test selected by CP0_IRQ_LATCH_EN).
`default_nettype none

module tb_cp0_nirq;
  localparam int N = 6;
  localparam logic [31:0] PRID = 32'h2004_0007;
  localparam logic [31:0] HADDR = 32'h0000_4180;

  logic         clk = 1'b0;
  logic         reset;
  logic         we;
  logic [4:0]   addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic [31:0]  pc;
  logic         bd;
  logic [4:0]   exc_code;
  logic [N-1:0] hw_int;
  logic         eret;
  logic         req;
  logic [31:0]  epc;
  logic [31:0]  vector;

  cp0_nirq #(.N_IRQ(N), .HANDLER_ADDR(HADDR), .PRID_VAL(PRID)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .pc(pc), .bd(bd), .exc_code(exc_code), .hw_int(hw_int), .eret(eret),
    .req(req), .epc(epc), .vector(vector)
  );

  always #20 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed %h with no expected value", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input string t, input logic [31:0] v);
    addr = a;
    push(t, v);
    #1;
    pop_cmp(rdata);
  endtask

  task automatic chk_req(input string t, input logic v);
    push(t, {31'd0, v});
    #1;
    pop_cmp({31'd0, req});
  endtask

  task automatic chk_epc(input string t, input logic [31:0] v);
    push(t, v);
    #1;
    pop_cmp(epc);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    cyc();
    we = 1'b0; wdata = 32'd0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    cyc();
    eret = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; addr = 5'd0; wdata = 32'd0; pc = 32'd0; bd = 1'b0;
    exc_code = 5'd0; hw_int = '0; eret = 1'b0;
    cyc(); cyc();
    reset = 1'b0;

    // Reset state
    rd(5'd12, "rst_sr", 32'd0);
    rd(5'd13, "rst_cause", 32'd0);
    rd(5'd14, "rst_epc", 32'd0);
    rd(5'd15, "rst_prid", PRID);
    chk_req("rst_req", 1'b0);
    push("vector", HADDR); #1; pop_cmp(vector);

    // Interrupt on line 0
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, "sr_write", 32'h0000_0401);
    hw_int = 6'b000001; pc = 32'h3008; bd = 1'b0;
    chk_req("irq0_req", 1'b1);
    cyc();
    chk_req("irq0_masked_exl", 1'b0);
    chk_epc("irq0_epc", 32'h3008);
    rd(5'd12, "irq0_sr", 32'h0000_0403);
    rd(5'd13, "irq0_cause", 32'h0000_0400);
    hw_int = '0;
    cyc();
    rd(5'd13, "ip_follows_level", 32'd0);

    // Interrupt beats exception, delay slot EPC
    do_eret();
    mtc0(5'd12, 32'h0000_1001);
    hw_int = 6'b000100; exc_code = 5'd4; bd = 1'b1; pc = 32'h3010;
    chk_req("prio_req", 1'b1);
    cyc();
    hw_int = '0; exc_code = 5'd0; bd = 1'b0;
    chk_epc("prio_epc", 32'h300C);
    rd(5'd13, "prio_cause", 32'h8000_1000);
    rd(5'd12, "prio_sr", 32'h0000_1003);

    // Masked while EXL, released by ERET
    exc_code = 5'd10; pc = 32'h3020;
    chk_req("exl_masks", 1'b0);
    eret = 1'b1;
    cyc();
    eret = 1'b0;
    rd(5'd12, "eret_clears_exl", 32'h0000_1001);
    chk_req("req_after_eret", 1'b1);
    cyc();
    exc_code = 5'd0;
    chk_epc("exc10_epc", 32'h3020);
    rd(5'd13, "exc10_cause", 32'h0000_0028);

    // Exception suppresses concurrent MTC0 EPC
    do_eret();
    we = 1'b1; addr = 5'd14; wdata = 32'h5000; exc_code = 5'd12; pc = 32'h3040;
    chk_req("wr_vs_exc_req", 1'b1);
    cyc();
    we = 1'b0; exc_code = 5'd0;
    chk_epc("wr_suppressed", 32'h3040);
    rd(5'd13, "exc12_cause", 32'h0000_0030);

    // Plain EPC write, Cause write ignored in level build
    do_eret();
    mtc0(5'd14, 32'h5003);
    chk_epc("epc_write", 32'h5003);
`ifndef CP0_IRQ_LATCH_EN
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, "cause_wr_ignored", 32'h0000_0030);
`endif

    // Same-cycle read and write returns old value
    we = 1'b1; addr = 5'd12; wdata = 32'd0;
    push("no_bypass", 32'h0000_1001); #1; pop_cmp(rdata);
    cyc();
    we = 1'b0;
    rd(5'd12, "sr_cleared", 32'd0);

    // Reset in the middle of a handler
    exc_code = 5'd8; pc = 32'h3100;
    cyc();
    rd(5'd12, "handler_exl", 32'h0000_0002);
    reset = 1'b1; eret = 1'b1; we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401;
    cyc();
    reset = 1'b0; eret = 1'b0; we = 1'b0; exc_code = 5'd0;
    rd(5'd12, "midrst_sr", 32'd0);
    rd(5'd13, "midrst_cause", 32'd0);
    chk_epc("midrst_epc", 32'd0);
    chk_req("midrst_req", 1'b0);

    // Pulse on line 1
    hw_int = 6'b000010;
    cyc();
    hw_int = '0;
`ifdef CP0_IRQ_LATCH_EN
    cyc();
    rd(5'd13, "latch_holds", 32'h0000_0800);
    cyc();
    rd(5'd13, "latch_still", 32'h0000_0800);
    mtc0(5'd13, 32'h0000_0800);
    cyc();
    rd(5'd13, "latch_w1c", 32'd0);
`else
    rd(5'd13, "level_high", 32'h0000_0800);
    cyc();
    rd(5'd13, "level_drop", 32'd0);
`endif

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries remaining, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/cp0_nirq.md
CP0_NIRQ -- requirements
Module: cp0_nirq

Interface
REQ-001 SHALL have parameter N_IRQ, 6, number of hardware interrupt lines, legal range 1..8.
REQ-002 SHALL have parameter HANDLER_ADDR, 32'h0000_4180, exception handler entry address.
REQ-003 SHALL have parameter PRID_VAL, 32'h2004_0007, value returned for register 15.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port we  input  1  MTC0 write enable.
REQ-007 SHALL have port addr  input  5  CP0 register number for read and write.
REQ-008 SHALL have port wdata  input  32  MTC0 write data.
REQ-009 SHALL have port rdata  output  32  MFC0 read data, combinational.
REQ-010 SHALL have port pc  input  32  M-stage PC of the victim instruction.
REQ-011 SHALL have port bd  input  1  victim sits in a branch delay slot.
REQ-012 SHALL have port exc_code  input  5  pending synchronous exception code; 0 means none.
REQ-013 SHALL have port hw_int  input  N_IRQ  hardware interrupt lines.
REQ-014 SHALL have port eret  input  1  ERET retiring in M stage.
REQ-015 SHALL have port req  output  1  take exception or interrupt this cycle.
REQ-016 SHALL have port epc  output  32  current EPC register value.
REQ-017 SHALL have port vector  output  32  constant HANDLER_ADDR.

Function
REQ-018 SHALL implement SR (12): IM at [9+N_IRQ:10], EXL at [1], IE at [0]; all other bits read 0.
REQ-019 SHALL implement Cause (13): BD at [31], IP at [9+N_IRQ:10], ExcCode at [6:2]; all other bits read 0.
REQ-020 SHALL implement EPC (14) and PRID (15); unimplemented addresses read 0 and ignore writes.
REQ-021 SHALL drive int_req = IE & ~EXL & |(IP_src & IM), where IP_src is the per-line pending source.
REQ-022 SHALL drive req = int_req | (~EXL & exc_code!=0), combinationally in the same cycle.
REQ-023 SHALL give interrupt priority over a simultaneous exception; recorded ExcCode is 0 in that case.
REQ-024 On req SHALL set EXL=1, BD=bd, ExcCode per REQ-023, and EPC = bd ? pc-4 : pc with bits [1:0] forced to 0.
REQ-025 SHALL update Cause.IP from IP_src every cycle, including cycles with EXL=1.
REQ-026 SHALL apply MTC0 to SR or EPC at the next edge when we=1 and req=0; req in the same cycle suppresses the write.
REQ-027 SHALL not permit software writes to Cause.BD or Cause.ExcCode.
REQ-028 On eret SHALL clear EXL at the next edge; req has priority over eret in the same cycle.
REQ-029 SHALL set rdata to the pre-edge register value for a same-cycle read and write (no bypass).
REQ-030 SHALL never raise req while EXL=1; nested exceptions are masked.

Reset
REQ-031 On reset SHALL clear SR, Cause, EPC, and any pending latches to 0; req reads 0 the cycle after.
REQ-032 SHALL give reset priority over req, we and eret in the same cycle; reset mid-handler clears EXL.

Configuration
REQ-033 With CP0_IRQ_LATCH_EN defined, IP_src SHALL be a per-line sticky latch set on a 0->1 edge of hw_int (one-cycle input register); MTC0 to Cause SHALL clear IP bits written as 1 (write-1-to-clear); a set and a clear on the same line in the same cycle leaves the latch set.
REQ-034 Without CP0_IRQ_LATCH_EN, IP_src SHALL equal hw_int (level-sensitive), and writes to Cause SHALL be ignored.

Verification
REQ-035 Reset, then read addrs 12/13/14/15 -> 0,0,0,PRID_VAL; req=0.
REQ-036 SR=32'h0000_0401, hw_int[0]=1, pc=32'h3008, bd=0 -> req=1 same cycle; next cycle EPC=32'h3008, EXL=1, ExcCode=0, req=0.
REQ-037 SR.IE=1 with IM[2]=1, hw_int[2]=1, exc_code=4, bd=1, pc=32'h3010 -> req=1; EPC=32'h300C, BD=1, ExcCode=0.
REQ-038 EXL=1, exc_code=10 -> req=0; assert eret -> EXL=0 next cycle, then req=1 the following cycle.
REQ-039 we=1, addr=14, wdata=32'h5000 concurrent with exc_code=12 -> EPC=pc, not 32'h5000.
REQ-040 Latch build: 1-cycle pulse on hw_int[1] -> IP[11] stays 1 after the line drops; MTC0 Cause wdata=32'h800 -> IP[11]=0. Level build: same pulse -> IP[11] follows hw_int.
